execute_redirect_ctrl: RTL

Sequences every front-end redirect in the execute stage. The block accepts a jump request from the execute jump stage or a redirect from the event/interrupt unit, gives event redirects priority, and holds the jump stage busy while the redirect is in progress. Each redirect runs in order: pipeline flush, optional TLB flush for page-directory changes, then a fetch-address handshake with the fetch unit.

---
 rtl/execute_redirect_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/execute_redirect_ctrl.sv
// Execute-stage front-end redirect sequencer: flush, optional TLB flush, fetch handshake.
// Optional prediction statistics counters are enabled by defining EXECUTE_REDIRECT_PREDICT_STAT_EN.
module execute_redirect_ctrl #(
  parameter int STAT_W = 32
) (
  input  logic              iCLOCK,
  input  logic              iRESET_SYNC,
  input  logic              iJUMP_VALID,
  input  logic [31:0]       iJUMP_ADDR,
  input  logic              iJUMP_SYSREG_PDT,
  input  logic              iJUMP_PREDICT_ENA,
  input  logic              iJUMP_PREDICT_HIT,
  input  logic              iEVENT_REQ,
  input  logic [31:0]       iEVENT_ADDR,
  output logic              oEVENT_ACK,
  output logic              oBUSY,
  output logic              oPIPE_FLUSH,
  output logic              oTLB_FLUSH_REQ,
  input  logic              iTLB_FLUSH_DONE,
  output logic              oFETCH_REQ,
  output logic [31:0]       oFETCH_ADDR,
  input  logic              iFETCH_ACK,
  output logic [STAT_W-1:0] oSTAT_HIT,
  output logic [STAT_W-1:0] oSTAT_MISS
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_TLB,
    ST_FETCH
  } state_t;

  state_t      state, state_next;
  logic [31:2] addr_q, addr_next;
  logic        pdt_q, pdt_next;
  logic        ack_q, ack_next;

  // Word-aligned target is kept; the low two address bits are never stored.
  always_comb begin
    state_next = state;
    addr_next  = addr_q;
    pdt_next   = pdt_q;
    ack_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (iEVENT_REQ) begin
          addr_next  = iEVENT_ADDR[31:2];
          pdt_next   = 1'b0;
          ack_next   = 1'b1;
          state_next = ST_FLUSH;
        end else if (iJUMP_VALID) begin
          addr_next  = iJUMP_ADDR[31:2];
          pdt_next   = iJUMP_SYSREG_PDT;
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: state_next = pdt_q ? ST_TLB : ST_FETCH;
      ST_TLB:   if (iTLB_FLUSH_DONE) state_next = ST_FETCH;
      ST_FETCH: if (iFETCH_ACK) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      pdt_q  <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      state  <= state_next;
      addr_q <= addr_next;
      pdt_q  <= pdt_next;
      ack_q  <= ack_next;
    end
  end

  assign oBUSY          = (state != ST_IDLE);
  assign oPIPE_FLUSH    = (state == ST_FLUSH);
  assign oTLB_FLUSH_REQ = (state == ST_TLB);
  assign oFETCH_REQ     = (state == ST_FETCH);
  assign oFETCH_ADDR    = {addr_q, 2'b00};
  assign oEVENT_ACK     = ack_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{iJUMP_ADDR[1:0], iEVENT_ADDR[1:0]};

`ifdef EXECUTE_REDIRECT_PREDICT_STAT_EN
  logic [STAT_W-1:0] hit_q, miss_q;
  logic [STAT_W-1:0] stat_one;
  logic              count_en;

  assign stat_one = {{(STAT_W-1){1'b0}}, 1'b1};
  assign count_en = iJUMP_PREDICT_ENA && (state == ST_IDLE);

  // A valid jump under prediction means the front end went the wrong way.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (count_en) begin
      if (iJUMP_PREDICT_HIT && !iJUMP_VALID) begin
        if (hit_q != '1) hit_q <= hit_q + stat_one;
      end else begin
        if (miss_q != '1) miss_q <= miss_q + stat_one;
      end
    end
  end

  assign oSTAT_HIT  = hit_q;
  assign oSTAT_MISS = miss_q;
`else
  logic unused_predict;
  assign unused_predict = ^{iJUMP_PREDICT_ENA, iJUMP_PREDICT_HIT};
  assign oSTAT_HIT      = '0;
  assign oSTAT_MISS     = '0;
`endif

endmodule
